// File: rtl/uart_rcv_param.sv
// Parametrised asynchronous serial receiver: oversampled frame decoder with
// optional parity, start-glitch rejection, sticky error flags and a receive FIFO.
module uart_rcv_param #(
    parameter int CLK_PER_BAUD = 2604,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        RX,
    input  logic                        rx_rdy_clr,
    input  logic                        err_clr,
    output logic                        rx_rdy,
    output logic [DATA_BITS-1:0]        rx_data,
    output logic [$clog2(FIFO_DEPTH):0] rx_count,
    output logic                        frame_err,
    output logic                        parity_err,
    output logic                        overrun
);

    localparam int              PW       = $clog2(FIFO_DEPTH);
    localparam int              CW       = PW + 1;
    localparam logic [11:0]     HALF_M1  = 12'(CLK_PER_BAUD / 2 - 1);
    localparam logic [11:0]     BAUD_M1  = 12'(CLK_PER_BAUD - 1);
    localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic [CW-1:0]   FULL     = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    logic                 ff1_q, ff2_q;
    logic                 fall;
    state_e               state_q, state_d;
    logic [11:0]          cnt_q, cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_ok_q, par_ok_d;
    logic                 pend_q, pend_d;
    logic                 set_frame, set_parity, set_ovr;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q, rd_next;
    logic [CW-1:0]        count_q, count_d;
    logic [DATA_BITS-1:0] head_q, head_d;
    logic                 pop, full, wr_en;
    logic                 frame_err_q, parity_err_q, overrun_q;

    // NOTE: sequential state always uses non-blocking (<=) so every flop samples
    // the pre-edge value of its neighbours; blocking here would collapse ff1/ff2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1_q <= 1'b1;
            ff2_q <= 1'b1;
        end else begin
            ff1_q <= RX;
            ff2_q <= ff1_q;
        end
    end

    assign fall = ~ff1_q & ff2_q;

    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_ok_d   = par_ok_q;
        pend_d     = 1'b0;
        set_frame  = 1'b0;
        set_parity = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    par_ok_d  = 1'b1;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = ff2_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == BAUD_M1) begin
                    cnt_d     = '0;
                    shift_d   = {ff2_q, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == LAST_BIT)
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            S_PARITY: begin
                if (cnt_q == BAUD_M1) begin
                    cnt_d    = '0;
                    par_ok_d = ((^shift_q) ^ ff2_q) == (PARITY == 1);
                    state_d  = S_STOP;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == BAUD_M1) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (!ff2_q)         set_frame  = 1'b1;
                    else if (!par_ok_q) set_parity = 1'b1;
                    else                pend_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_ok_q  <= 1'b1;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_ok_q  <= par_ok_d;
            pend_q    <= pend_d;
        end
    end

    // shift_q is stable during the pending cycle: the next data sample is at least HALF clocks away.
    assign pop     = rx_rdy_clr && (count_q != '0);
    assign full    = (count_q == FULL);
    assign wr_en   = pend_q && (!full || pop);
    assign set_ovr = pend_q && full && !pop;
    assign rd_next = rd_ptr_q + PW'(1);

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        if (wr_en && !pop)      count_d = count_q + CW'(1);
        else if (pop && !wr_en) count_d = count_q - CW'(1);
        if (pop) begin
            if (count_q > CW'(1)) head_d = mem_q[rd_next];
            else if (wr_en)       head_d = shift_q;
        end else if (wr_en && count_q == '0) begin
            head_d = shift_q;
        end
    end

    // NOTE: the storage array carries no reset; only pointers, count and the
    // head register do, which is all that defines the visible FIFO state.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_q       <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)   rd_ptr_q <= rd_next;
            count_q <= count_d;
            head_q  <= head_d;
            if (set_frame)    frame_err_q  <= 1'b1;
            else if (err_clr) frame_err_q  <= 1'b0;
            if (set_parity)   parity_err_q <= 1'b1;
            else if (err_clr) parity_err_q <= 1'b0;
            if (set_ovr)      overrun_q    <= 1'b1;
            else if (err_clr) overrun_q    <= 1'b0;
        end
    end

    assign rx_rdy     = (count_q != '0);
    assign rx_data    = head_q;
    assign rx_count   = count_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rcv_param.sv
// Directed bench for uart_rcv_param: an 8N1 instance (A) and a 7-bit even-parity
// instance (B), both at 16 clocks per bit with a 4-entry FIFO.
module tb_uart_rcv_param;

    localparam int CPB    = 16;
    localparam int HALF   = CPB / 2;
    localparam int LAT_LO = 2 + HALF + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_a = 1'b1, clr_a = 1'b0, eclr_a = 1'b0;
    logic       rx_b = 1'b1, clr_b = 1'b0, eclr_b = 1'b0;
    logic       rdy_a, fe_a, pe_a, ov_a;
    logic       rdy_b, fe_b, pe_b, ov_b;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic [2:0] cnt_a, cnt_b;

    int n_checks = 0;
    int n_err    = 0;
    int cyc;

    always #5 clk = ~clk;

    uart_rcv_param #(.CLK_PER_BAUD(CPB), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .RX(rx_a), .rx_rdy_clr(clr_a), .err_clr(eclr_a),
        .rx_rdy(rdy_a), .rx_data(data_a), .rx_count(cnt_a),
        .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a)
    );

    uart_rcv_param #(.CLK_PER_BAUD(CPB), .DATA_BITS(7), .PARITY(2), .FIFO_DEPTH(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .RX(rx_b), .rx_rdy_clr(clr_b), .err_clr(eclr_b),
        .rx_rdy(rdy_b), .rx_data(data_b), .rx_count(cnt_b),
        .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input bit sel, input logic v);
        if (sel) rx_b = v; else rx_a = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input int nbits, input bit has_par,
                        input logic par_bit, input logic stop_bit, input int idle);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(sel, d[i]);
        if (has_par) drive_bit(sel, par_bit);
        drive_bit(sel, stop_bit);
        if (sel) rx_b = 1'b1; else rx_a = 1'b1;
        repeat (idle) @(negedge clk);
    endtask

    task automatic pop(input bit sel);
        if (sel) clr_b = 1'b1; else clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        clr_b = 1'b0;
    endtask

    task automatic clear_errs(input bit sel);
        if (sel) eclr_b = 1'b1; else eclr_a = 1'b1;
        @(negedge clk);
        eclr_a = 1'b0;
        eclr_b = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_rdy_a", rdy_a, 0);
        check("rst_data_a", data_a, 8'h00);
        check("rst_cnt_a", cnt_a, 0);
        check("rst_flags_a", {fe_a, pe_a, ov_a}, 3'b000);
        check("rst_rdy_b", rdy_b, 0);
        check("rst_flags_b", {fe_b, pe_b, ov_b}, 3'b000);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single 8N1 frame with latency measured from the RX fall
        fork
            send(0, 8'hA5, 8, 0, 1'b0, 1'b1, 4);
            begin
                cyc = 0;
                while (!rdy_a && cyc < 400) begin
                    @(posedge clk);
                    cyc++;
                    @(negedge clk);
                end
            end
        join
        check("a5_latency_in_window", (cyc >= LAT_LO && cyc <= LAT_LO + 1), 1);
        check("a5_data", data_a, 8'hA5);
        check("a5_count", cnt_a, 1);
        pop(0);
        check("a5_pop_rdy", rdy_a, 0);
        check("a5_pop_count", cnt_a, 0);

        // Five frames into a 4-deep FIFO without popping
        for (int i = 1; i <= 5; i++) send(0, 8'(i), 8, 0, 1'b0, 1'b1, 4);
        check("ovr_count", cnt_a, 4);
        check("ovr_flag", ov_a, 1);
        for (int i = 1; i <= 4; i++) begin
            check("ovr_pop_data", data_a, 32'(i));
            pop(0);
        end
        check("ovr_drained_count", cnt_a, 0);
        check("ovr_drained_rdy", rdy_a, 0);
        pop(0);
        check("empty_pop_count", cnt_a, 0);
        clear_errs(0);
        check("ovr_cleared", ov_a, 0);

        // Even parity: 0x03 carries two ones, so a parity bit of 1 is wrong
        send(1, 8'h03, 7, 1, 1'b1, 1'b1, 4);
        check("par_bad_flag", pe_b, 1);
        check("par_bad_count", cnt_b, 0);
        clear_errs(1);
        check("par_cleared", pe_b, 0);
        send(1, 8'h03, 7, 1, 1'b0, 1'b1, 4);
        check("par_good_count", cnt_b, 1);
        check("par_good_data", data_b, 7'h03);
        check("par_good_flag", pe_b, 0);
        pop(1);

        // Stop bit low, then a clean frame
        send(0, 8'h5A, 8, 0, 1'b0, 1'b0, 4);
        check("frm_flag", fe_a, 1);
        check("frm_count", cnt_a, 0);
        send(0, 8'h3C, 8, 0, 1'b0, 1'b1, 4);
        check("frm_next_count", cnt_a, 1);
        check("frm_next_data", data_a, 8'h3C);
        pop(0);
        clear_errs(0);

        // Start-bit glitch shorter than half a bit
        rx_a = 1'b0;
        repeat (HALF - 2) @(negedge clk);
        rx_a = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_flags", {fe_a, pe_a, ov_a}, 3'b000);
        check("glitch_count", cnt_a, 0);
        send(0, 8'h96, 8, 0, 1'b0, 1'b1, 4);
        check("glitch_next_data", data_a, 8'h96);
        check("glitch_next_count", cnt_a, 1);
        pop(0);

        // Back-to-back 7-bit even-parity frames with no idle gap
        send(1, 8'h7F, 7, 1, 1'b1, 1'b1, 0);
        send(1, 8'h00, 7, 1, 1'b0, 1'b1, 4);
        check("b2b_count", cnt_b, 2);
        check("b2b_first", data_b, 7'h7F);
        pop(1);
        check("b2b_second", data_b, 7'h00);
        pop(1);
        check("b2b_flags", {fe_b, pe_b, ov_b}, 3'b000);

        // Reset in the middle of the data bits with a byte held and a flag set
        send(0, 8'h11, 8, 0, 1'b0, 1'b1, 4);
        send(0, 8'h22, 8, 0, 1'b0, 1'b0, 4);
        check("prerst_count", cnt_a, 1);
        check("prerst_frame", fe_a, 1);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b0);
        rst_n = 1'b0;
        rx_a  = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_rdy", rdy_a, 0);
        check("midrst_data", data_a, 8'h00);
        check("midrst_count", cnt_a, 0);
        check("midrst_flags", {fe_a, pe_a, ov_a}, 3'b000);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("postrst_idle_count", cnt_a, 0);
        send(0, 8'hC3, 8, 0, 1'b0, 1'b1, 4);
        check("postrst_data", data_a, 8'hC3);
        check("postrst_count", cnt_a, 1);
        check("postrst_flags", {fe_a, pe_a, ov_a}, 3'b000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
